// File: rtl/keysw_device.sv
// Memory-mapped KEY/SW responder: synchronizes, optionally debounces, latches events, raises irq.
// Optional debounce path selected by `define KEYSW_DEBOUNCE_EN.
module keysw_device #(
  parameter int unsigned      DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114,
  parameter logic [15:0]      DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] abus,
  input  logic [DBITS-1:0] dbus,
  input  logic             we,
  input  logic             re,
  input  logic [3:0]       key,
  input  logic [9:0]       sw,
  output logic [DBITS-1:0] rdata,
  output logic             hit,
  output logic             irq
);

  logic [3:0] ks1_q, ks2_q;
  logic [9:0] ss1_q, ss2_q;

  // KEY idles high, so its synchronizer resets to released
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ks1_q <= 4'hF;
      ks2_q <= 4'hF;
      ss1_q <= '0;
      ss2_q <= '0;
    end else begin
      ks1_q <= key;
      ks2_q <= ks1_q;
      ss1_q <= sw;
      ss2_q <= ss1_q;
    end
  end

  logic [3:0] kin;
  logic [9:0] sin;
  assign kin = ~ks2_q;
  assign sin = ss2_q;

  logic [3:0] kstate_q, kstate_d;
  logic [9:0] sstate_q, sstate_d;

`ifdef KEYSW_DEBOUNCE_EN
  localparam logic [15:0] TICK_LAST = DEBOUNCE_CYCLES - 16'd1;

  logic [15:0] cnt_q, cnt_d;
  logic        tick;
  logic [3:0]  ksamp_q, ksamp_d;
  logic [9:0]  ssamp_q, ssamp_d;
  logic [3:0]  kagree;
  logic [9:0]  sagree;

  assign tick   = (cnt_q == TICK_LAST);
  assign kagree = ~(kin ^ ksamp_q);
  assign sagree = ~(sin ^ ssamp_q);

  always_comb begin
    cnt_d    = tick ? 16'd0 : cnt_q + 16'd1;
    ksamp_d  = ksamp_q;
    ssamp_d  = ssamp_q;
    kstate_d = kstate_q;
    sstate_d = sstate_q;
    if (tick) begin
      ksamp_d  = kin;
      ssamp_d  = sin;
      // commit only bits whose two consecutive samples agree
      kstate_d = (kin & kagree) | (kstate_q & ~kagree);
      sstate_d = (sin & sagree) | (sstate_q & ~sagree);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      ksamp_q <= '0;
      ssamp_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ksamp_q <= ksamp_d;
      ssamp_q <= ssamp_d;
    end
  end
`else
  logic [15:0] unused_cfg;
  assign unused_cfg = DEBOUNCE_CYCLES;
  assign kstate_d   = kin;
  assign sstate_d   = sin;
`endif

  logic sel_key, sel_sw, sel_kctrl, sel_sctrl;
  assign sel_key   = (abus == ADDR_KEY);
  assign sel_sw    = (abus == ADDR_SW);
  assign sel_kctrl = (abus == ADDR_KCTRL);
  assign sel_sctrl = (abus == ADDR_SCTRL);

  logic rd_side, kclr, sclr, kwr, swr, kev, sev;
  assign rd_side = re & ~we;
  assign kclr    = rd_side & sel_key;
  assign sclr    = rd_side & sel_sw;
  assign kwr     = we & sel_kctrl;
  assign swr     = we & sel_sctrl;
  assign kev     = |(kstate_d & ~kstate_q);
  assign sev     = |(sstate_d ^ sstate_q);

  logic kready_q, kready_d, kovr_q, kovr_d, kie_q, kie_d;
  logic sready_q, sready_d, sovr_q, sovr_d, sie_q, sie_d;

  // new events win over clearing reads and W1C writes
  always_comb begin
    kready_d = kready_q;
    kovr_d   = kovr_q;
    kie_d    = kie_q;
    sready_d = sready_q;
    sovr_d   = sovr_q;
    sie_d    = sie_q;
    if (kclr) kready_d = 1'b0;
    if (kev)  kready_d = 1'b1;
    if (kwr && dbus[2]) kovr_d = 1'b0;
    if (kev && kready_q && !kclr) kovr_d = 1'b1;
    if (kwr) kie_d = dbus[8];
    if (sclr) sready_d = 1'b0;
    if (sev)  sready_d = 1'b1;
    if (swr && dbus[2]) sovr_d = 1'b0;
    if (sev && sready_q && !sclr) sovr_d = 1'b1;
    if (swr) sie_d = dbus[8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kstate_q <= '0;
      sstate_q <= '0;
      kready_q <= 1'b0;
      kovr_q   <= 1'b0;
      kie_q    <= 1'b0;
      sready_q <= 1'b0;
      sovr_q   <= 1'b0;
      sie_q    <= 1'b0;
    end else begin
      kstate_q <= kstate_d;
      sstate_q <= sstate_d;
      kready_q <= kready_d;
      kovr_q   <= kovr_d;
      kie_q    <= kie_d;
      sready_q <= sready_d;
      sovr_q   <= sovr_d;
      sie_q    <= sie_d;
    end
  end

  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    unique case (1'b1)
      sel_key:   rdata = {{(DBITS-4){1'b0}}, kstate_q};
      sel_sw:    rdata = {{(DBITS-10){1'b0}}, sstate_q};
      sel_kctrl: rdata = {{(DBITS-9){1'b0}}, kie_q, 5'b0,
                          kovr_q, 1'b0, kready_q};
      sel_sctrl: rdata = {{(DBITS-9){1'b0}}, sie_q, 5'b0,
                          sovr_q, 1'b0, sready_q};
      default:   hit   = 1'b0;
    endcase
  end

  assign irq = (kready_q & kie_q) | (sready_q & sie_q);

  logic unused_bits;
  assign unused_bits = ^{dbus[DBITS-1:9], dbus[7:3], dbus[1:0]};

endmodule
